// File: rtl/pdm_pkg.sv
// rtl/pdm_pkg.sv - shared width helpers, saturation function and PCM sample type for the PDM decimator
package pdm_pkg;

   localparam int PCM_W = 16;
   typedef logic signed [PCM_W-1:0] pcm_sample_t;

   // accumulator width that holds the full CIC gain R^N plus sign
   function automatic int acc_width(input int n, input int log2r);
      return n * log2r + 2;
   endfunction

   // right shift that maps the CIC full-scale range onto out_w bits
   function automatic int shift_amount(input int n, input int log2r, input int out_w);
      return n * log2r + 1 - out_w;
   endfunction

   // clamp a sign-extended value into the signed range of w bits
   function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/pdm_cic_comb_stage.sv
// rtl/pdm_cic_comb_stage.sv - one registered CIC comb stage, y = x - x_delayed, differential delay 1
module pdm_cic_comb_stage #(
   parameter int W = 26
) (
   input  logic                audio_clk,
   input  logic                reset,
   input  logic                in_valid,
   input  logic signed [W-1:0] in_data,
   output logic                out_valid,
   output logic signed [W-1:0] out_data
);

   logic signed [W-1:0] delay_q;

   // one comb step per decimated sample; the valid flag simply follows the input one cycle later
   always_ff @(posedge audio_clk) begin
      if (reset) begin
         delay_q   <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data <= in_data - delay_q;
            delay_q  <= in_data;
         end
      end
   end

endmodule

// File: rtl/pdm_cic_decimator.sv
// rtl/pdm_cic_decimator.sv - PDM to PCM CIC decimator with saturating output register; PDM_DC_BLOCK_EN adds a DC blocker
module pdm_cic_decimator
   import pdm_pkg::*;
#(
   parameter int N     = 4,
   parameter int LOG2R = 6,
   parameter int OUT_W = 16
) (
   input  logic                    audio_clk,
   input  logic                    reset,
   input  logic                    pdm_bit,
   input  logic                    pdm_valid,
   output logic signed [OUT_W-1:0] pcm_data,
   output logic                    pcm_valid,
   input  logic                    pcm_ready,
   output logic                    overrun
);

   localparam int ACC_W  = acc_width(N, LOG2R);
   localparam int SHIFT  = shift_amount(N, LOG2R, OUT_W);
   localparam int WARM_W = $clog2(N + 1);

   logic signed [ACC_W-1:0] pdm_in;
   logic signed [ACC_W-1:0] integ_q [N];
   logic signed [ACC_W-1:0] integ_d [N];
   logic [LOG2R-1:0]        dec_cnt_q;
   logic signed [ACC_W-1:0] cap_q;
   logic                    cap_valid_q;
   logic signed [ACC_W-1:0] comb_data [N+1];
   logic                    comb_valid [N+1];
   logic signed [ACC_W-1:0] shifted;
   logic signed [OUT_W-1:0] cic_sample;
   logic [WARM_W-1:0]       warm_cnt_q;
   logic                    warm_done;
   logic                    res_keep;
   logic                    load;
   logic signed [OUT_W-1:0] load_data;

   assign pdm_in = pdm_bit ? ACC_W'(1) : {ACC_W{1'b1}};

   // integrator cascade: each stage adds the already-updated output of the stage before it
   always_comb begin
      integ_d[0] = integ_q[0] + pdm_in;
      for (int k = 1; k < N; k++) begin
         integ_d[k] = integ_q[k] + integ_d[k-1];
      end
   end

   // integrators and decimation counter advance only on a strobe; modular wrap is intended
   always_ff @(posedge audio_clk) begin
      if (reset) begin
         for (int k = 0; k < N; k++) integ_q[k] <= '0;
         dec_cnt_q   <= '0;
         cap_q       <= '0;
         cap_valid_q <= 1'b0;
      end else begin
         cap_valid_q <= 1'b0;
         if (pdm_valid) begin
            for (int k = 0; k < N; k++) integ_q[k] <= integ_d[k];
            dec_cnt_q <= dec_cnt_q + LOG2R'(1);
            if (dec_cnt_q == '1) begin
               cap_q       <= integ_d[N-1];
               cap_valid_q <= 1'b1;
            end
         end
      end
   end

   assign comb_data[0]  = cap_q;
   assign comb_valid[0] = cap_valid_q;

   for (genvar g = 0; g < N; g++) begin : g_comb
      pdm_cic_comb_stage #(.W(ACC_W)) u_comb (
         .audio_clk (audio_clk),
         .reset     (reset),
         .in_valid  (comb_valid[g]),
         .in_data   (comb_data[g]),
         .out_valid (comb_valid[g+1]),
         .out_data  (comb_data[g+1])
      );
   end

   assign shifted    = comb_data[N] >>> SHIFT;
   assign cic_sample = OUT_W'(sat_to_width(64'(shifted), OUT_W));
   assign warm_done  = (warm_cnt_q == WARM_W'(N));
   assign res_keep   = comb_valid[N] && warm_done;

   // drop the first N results while the comb delays still hold start-up history
   always_ff @(posedge audio_clk) begin
      if (reset) begin
         warm_cnt_q <= '0;
      end else if (comb_valid[N] && !warm_done) begin
         warm_cnt_q <= warm_cnt_q + WARM_W'(1);
      end
   end

`ifdef PDM_DC_BLOCK_EN
   localparam int DC_W = OUT_W + 2;

   logic signed [DC_W-1:0]  dc_x_q;
   logic signed [DC_W-1:0]  dc_y_q;
   logic signed [DC_W-1:0]  dc_y_d;
   logic signed [OUT_W-1:0] dc_out_q;
   logic                    dc_valid_q;

   assign dc_y_d = DC_W'(cic_sample) - dc_x_q + dc_y_q - (dc_y_q >>> 8);

   // leaky differentiator: the y>>>8 leak places the pole just inside the unit circle
   always_ff @(posedge audio_clk) begin
      if (reset) begin
         dc_x_q     <= '0;
         dc_y_q     <= '0;
         dc_out_q   <= '0;
         dc_valid_q <= 1'b0;
      end else begin
         dc_valid_q <= res_keep;
         if (res_keep) begin
            dc_x_q   <= DC_W'(cic_sample);
            dc_y_q   <= dc_y_d;
            dc_out_q <= OUT_W'(sat_to_width(64'(dc_y_d), OUT_W));
         end
      end
   end

   assign load      = dc_valid_q;
   assign load_data = dc_out_q;
`else
   assign load      = res_keep;
   assign load_data = cic_sample;
`endif

   // 1-deep output slot: a new sample always wins; overwriting an unread one sets sticky overrun
   always_ff @(posedge audio_clk) begin
      if (reset) begin
         pcm_data  <= '0;
         pcm_valid <= 1'b0;
         overrun   <= 1'b0;
      end else if (load) begin
         pcm_data  <= load_data;
         pcm_valid <= 1'b1;
         if (pcm_valid && !pcm_ready) overrun <= 1'b1;
      end else if (pcm_ready) begin
         pcm_valid <= 1'b0;
      end
   end

endmodule
